// File: rtl/adc_pkg.sv
// Shared types and constants for the ADC paddle sampler.
// Imported by the sampler top and its averaging sub-module.
package adc_pkg;

  localparam int ADC_DATA_W  = 12;
  localparam int ADC_CH_W    = 5;
  localparam int SCALE_SHIFT = 12;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CMD      = 2'd1,
    WAIT_RSP = 2'd2
  } state_e;

endpackage

// File: rtl/adc_sample_avg.sv
// Block averager: sums 2^AVG_LOG2 accepted samples
// and emits their truncated mean with a one-cycle strobe.
module adc_sample_avg
  import adc_pkg::*;
#(
  parameter int AVG_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_valid,
  input  logic [ADC_DATA_W-1:0] i_sample,
  output logic [ADC_DATA_W-1:0] o_avg,
  output logic                  o_avg_valid
);

  localparam int ACC_W = ADC_DATA_W + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam int N     = 2 ** AVG_LOG2;

  logic [ACC_W-1:0]      r_acc;
  logic [CNT_W-1:0]      r_cnt;
  logic [ADC_DATA_W-1:0] r_avg;
  logic                  r_avg_valid;
  logic [ACC_W-1:0]      w_sum;
  logic                  w_last;

  assign w_sum  = r_acc + ACC_W'(i_sample);
  assign w_last = (r_cnt == CNT_W'(N - 1));

  // Accumulate samples; on the last of a block latch the mean and restart.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc       <= '0;
      r_cnt       <= '0;
      r_avg       <= '0;
      r_avg_valid <= 1'b0;
    end else begin
      r_avg_valid <= 1'b0;
      if (i_valid) begin
        if (w_last) begin
          r_avg       <= w_sum[ACC_W-1:AVG_LOG2];
          r_avg_valid <= 1'b1;
          r_acc       <= '0;
          r_cnt       <= '0;
        end else begin
          r_acc <= w_sum;
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign o_avg       = r_avg;
  assign o_avg_valid = r_avg_valid;

endmodule

// File: rtl/adc_paddle_sampler.sv
// Paces single-sample ADC commands, collects matching responses,
// averages them and scales the mean to a paddle x-coordinate.
module adc_paddle_sampler
  import adc_pkg::*;
#(
  parameter int CHANNEL    = 1,
  parameter int SAMPLE_DIV = 5000,
  parameter int AVG_LOG2   = 3,
  parameter int TIMEOUT    = 255,
  parameter int X_MAX      = 560,
  parameter int X_W        = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  adc_command_valid,
  output logic [ADC_CH_W-1:0]   adc_command_channel,
  output logic                  adc_command_startofpacket,
  output logic                  adc_command_endofpacket,
  input  logic                  adc_command_ready,
  input  logic                  adc_response_valid,
  input  logic [ADC_CH_W-1:0]   adc_response_channel,
  input  logic [ADC_DATA_W-1:0] adc_response_data,
  input  logic                  adc_response_startofpacket,
  input  logic                  adc_response_endofpacket,
  output logic [ADC_DATA_W-1:0] avg_out,
  output logic [X_W-1:0]        paddle_x,
  output logic                  sample_valid,
  output logic                  timeout_err
);

  localparam int TICK_W = $clog2(SAMPLE_DIV);
  localparam int TO_W   = $clog2(TIMEOUT + 1);
  localparam int PROD_W = ADC_DATA_W + X_W;

  state_e                r_state;
  state_e                w_state_nxt;
  logic [TICK_W-1:0]     r_tick;
  logic [TO_W-1:0]       r_to;
  logic                  r_timeout_err;
  logic [X_W-1:0]        r_px;
  logic                  r_sv;
  logic                  w_tick;
  logic                  w_match;
  logic                  w_accept;
  logic                  w_to_hit;
  logic [ADC_DATA_W-1:0] w_avg;
  logic                  w_avg_valid;
  logic [X_W-1:0]        w_px;
  logic [SCALE_SHIFT-1:0] w_unused_lo;
  logic                  w_unused;

  assign w_tick  = (r_tick == TICK_W'(SAMPLE_DIV - 1));
  assign w_match = adc_response_valid
                 && (adc_response_channel == ADC_CH_W'(CHANNEL));

  // Free-running sample-rate divider.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tick <= '0;
    end else if (w_tick) begin
      r_tick <= '0;
    end else begin
      r_tick <= r_tick + TICK_W'(1);
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, sample accept and timeout decisions.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_to_hit    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_tick) w_state_nxt = CMD;
      end
      CMD: begin
        if (adc_command_ready) w_state_nxt = WAIT_RSP;
      end
      WAIT_RSP: begin
        if (w_match) begin
          w_accept    = 1'b1;
          w_state_nxt = IDLE;
        end else if (r_to == TO_W'(TIMEOUT)) begin
          w_to_hit    = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Response wait counter, zero whenever not waiting.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_to <= '0;
    end else if (r_state == WAIT_RSP && w_state_nxt == WAIT_RSP) begin
      r_to <= r_to + TO_W'(1);
    end else begin
      r_to <= '0;
    end
  end

  // Sticky timeout flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_timeout_err <= 1'b0;
    end else if (w_to_hit) begin
      r_timeout_err <= 1'b1;
    end
  end

  adc_sample_avg #(
    .AVG_LOG2 (AVG_LOG2)
  ) u_avg (
    .clk         (clk),
    .reset       (reset),
    .i_valid     (w_accept),
    .i_sample    (adc_response_data),
    .o_avg       (w_avg),
    .o_avg_valid (w_avg_valid)
  );

  assign {w_px, w_unused_lo} = PROD_W'(w_avg) * PROD_W'(X_MAX);

  // Register the scaled position one cycle after a new average.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_px <= '0;
      r_sv <= 1'b0;
    end else begin
      r_sv <= w_avg_valid;
      if (w_avg_valid) r_px <= w_px;
    end
  end

  assign w_unused = ^{adc_response_startofpacket,
                      adc_response_endofpacket};

  assign adc_command_valid         = (r_state == CMD);
  assign adc_command_channel       = ADC_CH_W'(CHANNEL);
  assign adc_command_startofpacket = 1'b1;
  assign adc_command_endofpacket   = 1'b1;
  assign avg_out                   = w_avg;
  assign paddle_x                  = r_px;
  assign sample_valid              = r_sv;
  assign timeout_err               = r_timeout_err;

endmodule

// File: tb/tb_adc_paddle_sampler.sv
// Bench for adc_paddle_sampler: behavioural ADC driver
// plus a block-mean reference model and scoreboard.
module tb_adc_paddle_sampler;

  localparam int SD = 40;
  localparam int TO = 20;
  localparam int CH = 1;
  localparam int AL = 3;
  localparam int XM = 560;
  localparam int XW = 10;
  localparam int NB = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid;
  logic [4:0]    cmd_ch;
  logic          cmd_sop;
  logic          cmd_eop;
  logic          cmd_ready = 1'b0;
  logic          rsp_valid = 1'b0;
  logic [4:0]    rsp_ch = '0;
  logic [11:0]   rsp_data = '0;
  logic          rsp_sop = 1'b0;
  logic          rsp_eop = 1'b0;
  logic [11:0]   avg_out;
  logic [XW-1:0] paddle_x;
  logic          sample_valid;
  logic          timeout_err;

  adc_paddle_sampler #(
    .CHANNEL    (CH),
    .SAMPLE_DIV (SD),
    .AVG_LOG2   (AL),
    .TIMEOUT    (TO),
    .X_MAX      (XM),
    .X_W        (XW)
  ) dut (
    .clk                        (clk),
    .reset                      (reset),
    .adc_command_valid          (cmd_valid),
    .adc_command_channel        (cmd_ch),
    .adc_command_startofpacket  (cmd_sop),
    .adc_command_endofpacket    (cmd_eop),
    .adc_command_ready          (cmd_ready),
    .adc_response_valid         (rsp_valid),
    .adc_response_channel       (rsp_ch),
    .adc_response_data          (rsp_data),
    .adc_response_startofpacket (rsp_sop),
    .adc_response_endofpacket   (rsp_eop),
    .avg_out                    (avg_out),
    .paddle_x                   (paddle_x),
    .sample_valid               (sample_valid),
    .timeout_err                (timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  typedef struct {
    int avg;
    int px;
    int cyc;
  } exp_t;

  exp_t expq[$];
  exp_t mon_e;
  int   model_q[$];
  int   pulses = 0;
  int   blocks = 0;
  int   rel = 0;
  bit   first_after_rst = 1'b0;
  bit   m_terr = 1'b0;

  // Reference: every NB accepted samples yield floor(mean),
  // scaled as floor(mean * XM / 4096), seen 2 cycles later.
  function automatic void model_accept(int d, int c);
    model_q.push_back(d);
    if (model_q.size() == NB) begin
      int s;
      exp_t e;
      s = 0;
      foreach (model_q[k]) s += model_q[k];
      e.avg = s / NB;
      e.px  = (e.avg * XM) / 4096;
      e.cyc = c + 2;
      expq.push_back(e);
      blocks++;
      model_q.delete();
    end
  endfunction

  always @(negedge clk) begin
    if (sample_valid) begin
      pulses++;
      if (expq.size() == 0) begin
        chk("pulse_expected", expq.size(), 1);
      end else begin
        mon_e = expq.pop_front();
        chk("mon_avg_out", avg_out, mon_e.avg);
        chk("mon_paddle_x", paddle_x, mon_e.px);
        chk("mon_pulse_cycle", cyc, mon_e.cyc);
      end
    end
  end

  task automatic txn(input int d, input int rdly, input int lat,
                     input bit wrong, input bit early,
                     input bit norsp);
    int n;
    bit st;
    int pc;
    n = 0;
    while (!cmd_valid && n < 3 * SD) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_issued", cmd_valid, 1);
    if (!cmd_valid) return;
    if (first_after_rst) chk("first_cmd_cycle", cyc - rel, SD);
    else chk("cmd_spacing", (cyc - rel) % SD, 0);
    first_after_rst = 1'b0;
    st = 1'b1;
    for (int i = 0; i < rdly; i++) begin
      if (!(cmd_valid && cmd_ch == CH && cmd_sop && cmd_eop))
        st = 1'b0;
      @(negedge clk);
    end
    chk("cmd_stable",
        st && cmd_valid && cmd_ch == CH && cmd_sop && cmd_eop, 1);
    cmd_ready = 1'b1;
    if (early) begin
      rsp_valid = 1'b1;
      rsp_ch    = 5'(CH);
      rsp_data  = 12'(d ^ 'hFFF);
    end
    @(negedge clk);
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    chk("cmd_drop", cmd_valid, 0);
    if (norsp) begin
      repeat (TO) @(negedge clk);
      chk("terr_before", timeout_err, m_terr);
      @(negedge clk);
      m_terr = 1'b1;
      chk("terr_set", timeout_err, m_terr);
      chk("idle_no_cmd", cmd_valid, 0);
      return;
    end
    repeat (lat - 1) @(negedge clk);
    if (wrong) begin
      rsp_valid = 1'b1;
      rsp_ch    = 5'(CH + 1);
      rsp_data  = 12'(d ^ 'h5A5);
      @(negedge clk);
      rsp_valid = 1'b0;
    end
    rsp_valid = 1'b1;
    rsp_ch    = 5'(CH);
    rsp_data  = 12'(d);
    pc = cyc;
    @(negedge clk);
    rsp_valid = 1'b0;
    model_accept(d, pc);
    if (model_q.size() == 0)
      chk("avg_out_edge", avg_out, expq[$].avg);
    chk("terr_hold", timeout_err, m_terr);
  endtask

  typedef struct {
    logic [7:0][11:0] d;
    int avg;
    int px;
  } blk_t;

  blk_t tbl[4];

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cmd_valid"}, cmd_valid, 0);
    chk({tag, "_avg_out"}, avg_out, 0);
    chk({tag, "_paddle_x"}, paddle_x, 0);
    chk({tag, "_sample_valid"}, sample_valid, 0);
    chk({tag, "_timeout_err"}, timeout_err, 0);
  endtask

  initial begin
    int nr;
    int n;
    for (int k = 0; k < NB; k++) begin
      tbl[0].d[k] = 12'h800;
      tbl[1].d[k] = 12'(k);
      tbl[2].d[k] = 12'hFFF;
      tbl[3].d[k] = 12'h000;
    end
    tbl[0].avg = 'h800; tbl[0].px = 280;
    tbl[1].avg = 3;     tbl[1].px = 0;
    tbl[2].avg = 'hFFF; tbl[2].px = 559;
    tbl[3].avg = 0;     tbl[3].px = 0;

    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    reset = 1'b0;
    rel = cyc;
    first_after_rst = 1'b1;

    for (int b = 0; b < 4; b++) begin
      for (int k = 0; k < NB; k++) begin
        txn(int'(tbl[b].d[k]), (b == 0) ? 0 : k % 3,
            (b == 0) ? 3 : 1 + k % 4, 1'b0, 1'b0, 1'b0);
      end
      repeat (2) @(negedge clk);
      chk("blk_avg", avg_out, tbl[b].avg);
      chk("blk_px", paddle_x, tbl[b].px);
    end

    txn('h123, 10, 2, 1'b0, 1'b0, 1'b0);
    txn('h456, 0, 3, 1'b1, 1'b0, 1'b0);
    txn('h789, 0, 2, 1'b0, 1'b1, 1'b0);
    txn(0, 0, 1, 1'b0, 1'b0, 1'b1);
    txn('hABC, 1, 4, 1'b0, 1'b0, 1'b0);

    nr = 0;
    while ((nr < 12 || model_q.size() != 0) && nr < 40) begin
      txn(int'($urandom_range(0, 4095)), int'($urandom_range(0, 3)),
          int'($urandom_range(1, 5)), $urandom_range(0, 3) == 0,
          $urandom_range(0, 5) == 0, 1'b0);
      nr++;
    end

    for (int i = 0; i < 5; i++) begin
      txn(int'($urandom_range(0, 4095)), 0,
          int'($urandom_range(1, 4)), 1'b0, 1'b0, 1'b0);
    end
    chk("partial_count", model_q.size(), 5);

    n = 0;
    while (!cmd_valid && n < 3 * SD) begin
      @(negedge clk);
      n++;
    end
    chk("rst_cmd_issued", cmd_valid, 1);
    cmd_ready = 1'b1;
    @(negedge clk);
    cmd_ready = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("mid");
    reset = 1'b0;
    rel = cyc;
    first_after_rst = 1'b1;
    m_terr = 1'b0;
    model_q.delete();

    for (int i = 0; i < NB; i++) begin
      txn(int'($urandom_range(0, 4095)), int'($urandom_range(0, 2)),
          int'($urandom_range(1, 5)), 1'b0, 1'b0, 1'b0);
      if (i == NB - 2) chk("fresh_no_pulse", pulses, blocks);
    end

    repeat (4) @(negedge clk);
    chk("pulse_count", pulses, blocks);
    chk("expq_empty", expq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
